// File: rtl/mau_pkg.sv
// Shared encodings and address map for the M-stage load/store unit.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  // Matches the W-stage load extender select.
  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ld_sel_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  localparam logic [31:0] MAU_DM_TOP    = 32'h0000_2FFF;
  localparam logic [31:0] MAU_DEV0_BASE = 32'h0000_7F00;
  localparam logic [31:0] MAU_DEV1_BASE = 32'h0000_7F10;
  localparam logic [31:0] DEV_SPAN      = 32'd12;  // 3 words per timer
  localparam logic [31:0] DEV_COUNT_OFS = 32'd8;   // read-only count register

endpackage

// File: rtl/mau_bus_if.sv
// Request/ack data bus between the load/store unit and DM/timer devices.
interface mau_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mau_addr_check.sv
// Address legality, exception code, byte enables and store-data replication.
module mau_addr_check
  import mau_pkg::*;
#(
  parameter logic [31:0] DM_TOP    = MAU_DM_TOP,
  parameter logic [31:0] DEV0_BASE = MAU_DEV0_BASE,
  parameter logic [31:0] DEV1_BASE = MAU_DEV1_BASE
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [4:0]  exc_code,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata
);

  logic        in_dm, in_dev0, in_dev1, in_dev, aligned, is_word;
  logic [31:0] dev_ofs;

  // Decode the address map and access shape, then combine into legality.
  always_comb begin
    in_dm     = (addr <= DM_TOP);
    in_dev0   = (addr >= DEV0_BASE) && ((addr - DEV0_BASE) < DEV_SPAN);
    in_dev1   = (addr >= DEV1_BASE) && ((addr - DEV1_BASE) < DEV_SPAN);
    in_dev    = in_dev0 | in_dev1;
    dev_ofs   = in_dev1 ? (addr - DEV1_BASE) : (addr - DEV0_BASE);
    aligned   = 1'b0;
    is_word   = 1'b0;
    be        = '0;
    bus_wdata = wdata;
    case (size_e'(size))
      SZ_WORD: begin
        aligned = (addr[1:0] == 2'b00);
        is_word = 1'b1;
        be      = 4'b1111;
      end
      SZ_HALF: begin
        aligned   = ~addr[0];
        be        = addr[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        aligned   = 1'b1;
        be        = 4'b0001 << addr[1:0];
        bus_wdata = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    legal = aligned && (in_dm || in_dev)
            && !(in_dev && !is_word)
            && !(in_dev && we && (dev_ofs == DEV_COUNT_OFS));
    exc_code = we ? EXC_ADES : EXC_ADEL;
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: legality check, bus transaction FSM, W-stage capture.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] DM_TOP    = MAU_DM_TOP,
  parameter logic [31:0] DEV0_BASE = MAU_DEV0_BASE,
  parameter logic [31:0] DEV1_BASE = MAU_DEV1_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [2:0]        req_ld_sel,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [31:0]       bad_vaddr,
  mau_bus_if.master         bus,
  output logic              wb_valid,
  output logic [31:0]       wb_rdata,
  output logic [1:0]        wb_a,
  output logic [2:0]        wb_ld_sel
);

  state_e      state;
  logic        legal, accept, is_load, drop;
  logic [4:0]  chk_code;
  logic [3:0]  chk_be;
  logic [31:0] chk_wdata;
  logic [2:0]  ld_sel_q;
  logic [1:0]  a_q;

  mau_addr_check #(
    .DM_TOP   (DM_TOP),
    .DEV0_BASE(DEV0_BASE),
    .DEV1_BASE(DEV1_BASE)
  ) u_addr_check (
    .addr     (req_addr),
    .size     (req_size),
    .we       (req_we),
    .wdata    (req_wdata),
    .legal    (legal),
    .exc_code (chk_code),
    .be       (chk_be),
    .bus_wdata(chk_wdata)
  );

  // Combinational outputs are gated by reset so every output reads 0 while held.
  always_comb begin
    accept    = (state == S_IDLE) && req_valid && legal && !flush;
    stall     = reset && (accept || (state == S_REQ));
    exc_valid = reset && (state == S_IDLE) && req_valid && !legal && !flush;
    exc_code  = exc_valid ? chk_code : '0;
    bad_vaddr = exc_valid ? req_addr : '0;
  end

  // Transaction FSM plus bus and W-stage registers.
  // A flush coinciding with the ack still counts as a drop for that ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= '0;
      bus.wdata <= '0;
      is_load   <= 1'b0;
      drop      <= 1'b0;
      ld_sel_q  <= '0;
      a_q       <= '0;
      wb_valid  <= 1'b0;
      wb_rdata  <= '0;
      wb_a      <= '0;
      wb_ld_sel <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_REQ;
            bus.req   <= 1'b1;
            bus.we    <= req_we;
            bus.addr  <= {req_addr[31:2], 2'b00};
            bus.be    <= chk_be;
            bus.wdata <= chk_wdata;
            is_load   <= ~req_we;
            drop      <= 1'b0;
            ld_sel_q  <= req_ld_sel;
            a_q       <= req_addr[1:0];
          end
        end
        S_REQ: begin
          if (flush) drop <= 1'b1;
          if (bus.ack) begin
            bus.req <= 1'b0;
            state   <= S_RESP;
            if (is_load && !(drop || flush)) begin
              wb_rdata  <= bus.rdata;
              wb_a      <= a_q;
              wb_ld_sel <= ld_sel_q;
            end
          end
        end
        S_RESP: begin
          wb_valid <= is_load && !drop;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, flush;
  logic [1:0]  req_size;
  logic [2:0]  req_ld_sel;
  logic [31:0] req_addr, req_wdata;
  logic        stall, exc_valid, wb_valid;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr, wb_rdata;
  logic [1:0]  wb_a;
  logic [2:0]  wb_ld_sel;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Expected W-stage registers, updated only by completed, non-dropped loads.
  logic [31:0] exp_wb_rdata = '0;
  logic [1:0]  exp_wb_a     = '0;
  logic [2:0]  exp_wb_ld_sel = '0;

  always #5 clk = ~clk;

  mau_bus_if bus();

  mem_access_unit #(
    .DM_TOP   (32'h0000_2FFF),
    .DEV0_BASE(32'h0000_7F00),
    .DEV1_BASE(32'h0000_7F10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_ld_sel(req_ld_sel),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .flush     (flush),
    .stall     (stall),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr),
    .bus       (bus),
    .wb_valid  (wb_valid),
    .wb_rdata  (wb_rdata),
    .wb_a      (wb_a),
    .wb_ld_sel (wb_ld_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 4;
    if (sz == 2'd1) return 2;
    return 1;
  endfunction

  function automatic bit ref_legal(input logic [31:0] addr, input logic [1:0] sz, input bit we);
    int unsigned n = ref_nbytes(sz);
    bit in_dm = (addr <= 32'h2FFF);
    bit in_tmr = 0;
    logic [31:0] ofs = '0;
    if (addr >= 32'h7F00 && addr - 32'h7F00 < 12) begin in_tmr = 1; ofs = addr - 32'h7F00; end
    if (addr >= 32'h7F10 && addr - 32'h7F10 < 12) begin in_tmr = 1; ofs = addr - 32'h7F10; end
    if (addr % n != 0) return 0;
    if (!in_dm && !in_tmr) return 0;
    if (in_tmr && n != 4) return 0;
    if (in_tmr && we && ofs == 8) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] sz);
    int unsigned m = (32'd1 << ref_nbytes(sz)) - 1;
    m = m << (addr % 4);
    return m[3:0];
  endfunction

  // Byte lane i carries data byte (i mod access size): the replication rule.
  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r = '0;
    int unsigned n = ref_nbytes(sz);
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  // One M-stage access from IDLE, with the bench acting as bus slave.
  // ack arrives in REQ cycle wait_n+1; flush pulses in REQ cycle flush_k (0 = none).
  task automatic do_access(input bit we, input logic [1:0] sz, input logic [2:0] ld_sel,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned wait_n, input int unsigned flush_k,
                           input bit flush_idle);
    bit legal = ref_legal(addr, sz, we);
    bit dropped = 0;
    int unsigned stalls = 0;
    logic [31:0] rd;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_size = sz; req_ld_sel = ld_sel;
    req_addr = addr; req_wdata = wd; flush = flush_idle;
    @(negedge clk);
    if (!legal || flush_idle) begin
      check_eq("exc_valid", exc_valid, 32'(!legal && !flush_idle));
      if (!legal && !flush_idle) begin
        check_eq("exc_code", exc_code, we ? 5 : 4);
        check_eq("bad_vaddr", bad_vaddr, addr);
      end
      check_eq("idle_stall", stall, 0);
      @(posedge clk); #1;
      req_valid = 0; flush = 0;
      @(negedge clk);
      check_eq("no_bus_req", bus.req, 0);
      return;
    end
    check_eq("exc_valid_legal", exc_valid, 0);
    if (stall) stalls++;
    rd = '0;
    for (int unsigned k = 1; k <= wait_n + 1; k++) begin
      @(posedge clk); #1;
      bus.ack = (k == wait_n + 1);
      rd = $urandom;
      bus.rdata = rd;
      flush = (k == flush_k);
      if (k == flush_k) dropped = 1;
      @(negedge clk);
      if (stall) stalls++;
      check_eq("req_bus_req", bus.req, 1);
      check_eq("req_bus_we", bus.we, 32'(we));
      check_eq("req_bus_addr", bus.addr, addr & 32'hFFFF_FFFC);
      check_eq("req_bus_be", bus.be, ref_be(addr, sz));
      check_eq("req_bus_wdata", bus.wdata, ref_wdata(wd, sz));
    end
    if (!we && !dropped) begin
      exp_wb_rdata = rd; exp_wb_a = addr[1:0]; exp_wb_ld_sel = ld_sel;
    end
    @(posedge clk); #1;
    bus.ack = 0; flush = 0; bus.rdata = $urandom;
    @(negedge clk);
    if (stall) stalls++;
    check_eq("stall_cycles", stalls, wait_n + 2);
    check_eq("resp_bus_req", bus.req, 0);
    check_eq("resp_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    check_eq("wb_valid", wb_valid, 32'(!we && !dropped));
    check_eq("wb_rdata", wb_rdata, exp_wb_rdata);
    check_eq("wb_a", wb_a, 32'(exp_wb_a));
    check_eq("wb_ld_sel", wb_ld_sel, 32'(exp_wb_ld_sel));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_exc_valid"}, exc_valid, 0);
    check_eq({tag, "_bad_vaddr"}, bad_vaddr, 0);
    check_eq({tag, "_bus_req"}, bus.req, 0);
    check_eq({tag, "_bus_addr"}, bus.addr, 0);
    check_eq({tag, "_bus_be"}, bus.be, 0);
    check_eq({tag, "_wb_valid"}, wb_valid, 0);
    check_eq({tag, "_wb_rdata"}, wb_rdata, 0);
    check_eq({tag, "_wb_a"}, wb_a, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bit          we;
    int unsigned w, fk;
    reset = 0; req_valid = 0; req_we = 0; req_size = 0; req_ld_sel = 0;
    req_addr = 0; req_wdata = 0; flush = 0;
    bus.ack = 0; bus.rdata = 0;
    // Illegal request presented while reset is held must not raise anything.
    req_valid = 1; req_addr = 32'h0000_0102;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    req_valid = 0;
    reset = 1;

    // Directed cases.
    do_access(0, 2'b00, 3'b000, 32'h0000_0104, 32'h0, 0, 0, 0);    // lw, ack first REQ cycle
    do_access(1, 2'b10, 3'b000, 32'h0000_0013, 32'h1234_56AB, 0, 0, 0); // sb
    do_access(1, 2'b01, 3'b000, 32'h0000_0012, 32'h1234_56AB, 1, 0, 0); // sh upper half
    do_access(0, 2'b00, 3'b000, 32'h0000_0102, 32'h0, 0, 0, 0);    // misaligned lw
    do_access(1, 2'b00, 3'b000, 32'h0000_7F08, 32'h0, 0, 0, 0);    // sw timer count
    do_access(0, 2'b01, 3'b001, 32'h0000_7F00, 32'h0, 0, 0, 0);    // lh timer
    do_access(1, 2'b00, 3'b000, 32'h0000_3000, 32'h0, 0, 0, 0);    // sw past DM
    do_access(0, 2'b00, 3'b000, 32'h0000_2FFC, 32'h0, 0, 0, 0);    // last DM word
    do_access(0, 2'b00, 3'b000, 32'h0000_7F18, 32'h0, 1, 0, 0);    // timer1 count read
    do_access(0, 2'b10, 3'b011, 32'h0000_0221, 32'h0, 4, 0, 0);    // lb with wait states
    do_access(0, 2'b00, 3'b000, 32'h0000_0040, 32'h0, 3, 2, 0);    // flush in REQ
    do_access(0, 2'b00, 3'b000, 32'h0000_0044, 32'h0, 0, 0, 1);    // flush in IDLE

    // Asynchronous reset in the middle of REQ.
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_size = 2'b00; req_ld_sel = 3'b000;
    req_addr = 32'h0000_0200; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("pre_reset_bus_req", bus.req, 1);
    #2 reset = 0;
    #1 check_all_zero("mid_reset");
    exp_wb_rdata = '0; exp_wb_a = '0; exp_wb_ld_sel = '0;
    @(negedge clk);
    check_eq("reset_held_stall", stall, 0);
    reset = 1; req_valid = 0;
    do_access(0, 2'b00, 3'b000, 32'h0000_0208, 32'h0, 1, 0, 0);

    // Randomized accesses against the reference model.
    for (int unsigned it = 0; it < 150; it++) begin
      sz = 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 32'h2FFF));
        2:    a = 32'h7F00 + 32'($urandom_range(0, 15));
        3:    a = 32'h7F10 + 32'($urandom_range(0, 15));
        4:    a = 32'h2FF0 + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(ref_nbytes(sz)) - 1);
      w  = $urandom_range(0, 3);
      fk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, w + 1) : 0;
      do_access(we, sz, 3'($urandom_range(0, 4)), a, $urandom, w, fk,
                $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- M-stage load/store unit for the pipelined MIPS core with interrupts/exceptions.
- Checks address legality and raises AdEL/AdES.
- Generates byte enables and replicated store data, then runs a request/ack transaction on the data bus (DM or timer devices), stalling the pipeline until the ack.
- Registers the raw read word, address low bits and load-select for the W-stage load extender (`Din`, `A`, `Lw_sel`).

Parameters:
- DM_TOP, 32'h0000_2FFF, last legal data-memory byte address.
- DEV0_BASE, 32'h0000_7F00, timer0 base (3 words).
- DEV1_BASE, 32'h0000_7F10, timer1 base (3 words).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- req_valid  in  1  M-stage instruction is a load/store
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 word, 01 half, 10 byte
- req_ld_sel  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rt)
- flush  in  1  pipeline flush (exception/eret)
- stall  out  1  freeze PC/F/D/E/M
- exc_valid  out  1  address exception this cycle
- exc_code  out  5  4=AdEL, 5=AdES
- bad_vaddr  out  32  faulting address
- bus_req  out  1  transaction request
- bus_we  out  1  write
- bus_addr  out  32  word-aligned address
- bus_be  out  4  byte enables
- bus_wdata  out  32  replicated store data
- bus_ack  in  1  transaction complete
- bus_rdata  in  32  read word, valid with bus_ack
- wb_valid  out  1  load result valid for W stage
- wb_rdata  out  32  raw read word
- wb_a  out  2  req_addr[1:0] of the load
- wb_ld_sel  out  3  load select of the load

Behaviour:
- Reset: state IDLE. All outputs are 0.
- Legality (combinational):
  - Misaligned access (word with addr[1:0]!=0, half with addr[0]!=0) is illegal.
  - Address outside DM [0, DM_TOP] and outside both timer windows is illegal.
  - Half or byte access to a timer is illegal.
  - A store to timer offset 8 (count register) is illegal.
- Illegal request in IDLE:
  - exc_valid=1 in the same cycle, with exc_code 4 for a load and 5 for a store.
  - bad_vaddr=req_addr.
  - No bus activity, no stall.
  - exc_valid is 0 whenever flush=1.
- Byte enables and data:
  - Word: bus_be=1111.
  - Half: bus_be=1100 if addr[1], else 0011.
  - Byte: bus_be=0001<<addr[1:0].
  - bus_wdata is {2{wdata[15:0]}} for half, {4{wdata[7:0]}} for byte, wdata for word.
  - bus_addr={addr[31:2],2'b00}.
- FSM IDLE -> REQ -> RESP -> IDLE:
  - IDLE: on a legal req_valid with !flush, stall=1 combinationally. Register bus_* fields, we, size, ld_sel and addr[1:0]. Go to REQ.
  - REQ: bus_req=1, with bus_* held stable; stall=1. On bus_ack: for a load, capture bus_rdata, addr[1:0] and ld_sel into wb_*. Go to RESP. No timeout.
  - RESP: stall=0 and bus_req=0, so the instruction advances to W. Next state is IDLE. wb_valid is registered high for exactly the following cycle if the access was a load and was not dropped.
- Latency: ack in the first REQ cycle gives 2 stall cycles. Each extra wait cycle adds one.
- wb_rdata, wb_a and wb_ld_sel hold their values until the next load ack.
- Back-to-back requests: a request is considered only in IDLE, so the minimum issue interval is 3 cycles.
- Flush:
  - Flush in IDLE discards the request.
  - Flush in REQ sets a drop flag. bus_req stays high until ack, since the bus cannot abort. Stall stays 1 until ack. On ack, wb_* are not updated and wb_valid stays 0. A store already issued still completes on the bus.
  - Flush in RESP has no effect on completion.
- Asynchronous reset mid-transaction: return to IDLE immediately and drop bus_req. The bus must tolerate this.

Decomposition:
- Package mau_pkg holds:
  - size and ld_sel encodings (ld_sel matches the W-stage extender select);
  - exc codes AdEL=4 and AdES=5;
  - FSM state enum;
  - address-map constants.
- One combinational sub-module, mau_addr_check: takes addr, size and we, and outputs legal, exc_code, be and the replicated wdata.
- The FSM and the wb_* registers stay in the top module.

Test Plan:
- Legal load: lw 0x0000_0104 with DM returning 0xDEADBEEF on the 1st REQ cycle. Expect stall high for 2 cycles, bus_be=1111. wb_valid pulses with wb_rdata=0xDEADBEEF, wb_a=00, wb_ld_sel=000.
- Store fields: sb addr 0x0000_0013 with wdata 0x1234_56AB. Expect bus_addr 0x0000_0010, bus_be=1000, bus_wdata 0xABABABAB, wb_valid stays 0. Also sh addr 0x...02 gives be=1100 and wdata {2{0x56AB}}.
- Exceptions:
  - lw addr 0x0000_0102: exc_valid=1, exc_code=4, bad_vaddr=0x102, no bus_req, no stall.
  - sw to 0x0000_7F08: exc_code=5.
  - lh to 0x0000_7F00: exc_code=4.
  - sw 0x0000_3000: exc_code=5.
- Wait states: bus_ack delayed 5 cycles. Expect stall held for 6 cycles and bus_addr/be/wdata stable throughout REQ.
- Flush in REQ: assert flush in the 2nd REQ cycle of a load, ack in the 4th. Expect bus_req held until ack, stall released after RESP, wb_valid=0, wb_rdata unchanged.
- Reset mid-REQ: pull reset low during REQ. Expect bus_req=0, stall=0 and all outputs 0 immediately. After release, a new legal request is accepted.
